// File: rtl/mult_sched_pkg.sv
// Shared state encoding, default widths and the round-robin wrap helper
// used by the multiplier job scheduler.
package mult_sched_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_TMO_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ACK     = 3'd5
  } sched_state_e;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/mult_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping round to index 0.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'(rr_wrap(int'(ptr), k, NREQ));
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_job_scheduler.sv
// Round-robin scheduler sharing one multiplier core among NREQ requesters:
// grant, launch with a one-cycle start, wait for done or watchdog, ack.
//
//   state   | meaning
//   IDLE    | no job; waiting for any req
//   ARB     | pick requester, latch index/address
//   LAUNCH  | core_start high, grant asserted
//   RELEASE | start dropped, watchdog cleared
//   RUN     | waiting for core_done or watchdog saturation
//   ACK     | one-cycle ack (+err) to the granted requester
module mult_job_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TMO_W  = DEF_TMO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic                     core_start,
  output logic [ADDR_W-1:0]        core_addr,
  input  logic                     core_done,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NREQ);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  wd_q, wd_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [ADDR_W-1:0] arb_addr;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    arb_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) arb_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) state_d = ST_ARB;
      end
      ST_ARB: begin
        // req may have been withdrawn between IDLE and ARB
        if (arb_valid) begin
          idx_d   = arb_idx;
          gnt_d   = arb_gnt;
          addr_d  = arb_addr;
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: state_d = ST_RELEASE;
      ST_RELEASE: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wd_d = wd_q + TMO_W'(1);
        if (core_done) begin
          err_d   = 1'b0;
          state_d = ST_ACK;
        end else if (&wd_q) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = (idx_q == IDX_W'(NREQ-1)) ? '0 : idx_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant      = '0;
    ack        = '0;
    err        = 1'b0;
    core_start = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_LAUNCH: begin
        core_start = 1'b1;
        grant      = gnt_q;
      end
      ST_RELEASE, ST_RUN: grant = gnt_q;
      ST_ACK: begin
        grant = gnt_q;
        ack   = gnt_q;
        err   = err_q;
      end
      default: ;
    endcase
  end

  assign core_addr = addr_q;

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Randomised and directed bench for mult_job_scheduler against a
// job-level behavioural model, plus literal spot checks.
`timescale 1ns/1ps
module tb_mult_job_scheduler;

  localparam int NREQ    = 4;
  localparam int ADDR_W  = 4;
  localparam int TMO_W   = 10;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic                   core_done = 1'b0;
  logic [NREQ-1:0]        grant, ack;
  logic                   err, core_start, busy;
  logic [ADDR_W-1:0]      core_addr;

  mult_job_scheduler #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .grant(grant), .ack(ack), .err(err), .core_start(core_start),
    .core_addr(core_addr), .core_done(core_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // ---------------- behavioural model (job timeline) ----------------
  logic [NREQ-1:0]   e_grant = '0, e_ack = '0;
  logic              e_err = 1'b0, e_start = 1'b0, e_busy = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  int                m_ptr = 0;
  bit                m_abort = 1'b0;

  task automatic m_clear();
    e_grant = '0; e_ack = '0; e_err = 1'b0; e_start = 1'b0; e_busy = 1'b0;
    e_addr = '0; m_ptr = 0;
  endtask

  task automatic m_edge();
    @(posedge clk or posedge rst);
    if (rst) begin
      m_clear();
      m_abort = 1'b1;
    end
  endtask

  task automatic m_job();
    int pick, n;
    bit to;
    e_busy = 1'b1;                     // arbitration cycle
    m_edge(); if (m_abort) return;
    pick = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (pick < 0 && ((req >> j) & NREQ'(1)) != '0) pick = j;
    end
    if (pick < 0) begin
      e_busy = 1'b0;
      return;
    end
    e_start = 1'b1;
    e_grant = NREQ'(1) << pick;
    e_addr  = ADDR_W'(req_addr >> (pick * ADDR_W));
    m_edge(); if (m_abort) return;
    e_start = 1'b0;
    m_edge(); if (m_abort) return;     // core now running
    n = 0;
    to = 1'b0;
    forever begin
      m_edge(); if (m_abort) return;
      if (core_done) begin to = 1'b0; break; end
      if (n == TMO_MAX) begin to = 1'b1; break; end
      n++;
    end
    e_ack = e_grant;
    e_err = to;
    m_edge(); if (m_abort) return;
    e_ack = '0; e_err = 1'b0; e_grant = '0; e_busy = 1'b0;
    m_ptr = (pick + 1) % NREQ;
  endtask

  initial forever begin
    m_abort = 1'b0;
    @(posedge clk or posedge rst);
    if (rst) m_clear();
    else if (req != '0) m_job();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("grant",      32'(grant),      32'(e_grant));
    check("ack",        32'(ack),        32'(e_ack));
    check("err",        32'(err),        32'(e_err));
    check("core_start", 32'(core_start), 32'(e_start));
    check("core_addr",  32'(core_addr),  32'(e_addr));
    check("busy",       32'(busy),       32'(e_busy));
  end

  // ---------------- core responder ----------------
  int done_delay = 3;
  bit rand_delay = 1'b0;
  bit stray_now = 1'b0;
  bit stray_on_start = 1'b0;
  int cd = -1;

  initial forever begin
    @(negedge clk);
    core_done = stray_now;
    if (rst) begin
      cd = -1;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_done = 1'b1;
          cd = -1;
        end
      end
      if (core_start) begin
        if (stray_on_start) core_done = 1'b1;
        if (rand_delay) cd = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(2, 30));
        else cd = done_delay;
      end
    end
  end

  // ---------------- monitor ----------------
  int                starts_q[$];
  int                acks = 0;
  int                last_start_cyc = 0, last_ack_cyc = 0;
  logic [ADDR_W-1:0] last_start_addr = '0;
  logic [NREQ-1:0]   last_ack = '0;
  logic              last_err = 1'b0;

  initial forever begin
    @(negedge clk);
    if (core_start) begin
      int g;
      g = -1;
      for (int i = 0; i < NREQ; i++) if (grant == (NREQ'(1) << i)) g = i;
      starts_q.push_back(g);
      last_start_cyc  = cyc;
      last_start_addr = core_addr;
    end
    if (ack != '0) begin
      acks++;
      last_ack     = ack;
      last_err     = err;
      last_ack_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] v);
    logic [NREQ*ADDR_W-1:0] m;
    m = (NREQ*ADDR_W)'({ADDR_W{1'b1}}) << (i * ADDR_W);
    req_addr = (req_addr & ~m) | ((NREQ*ADDR_W)'(v) << (i * ADDR_W));
  endtask

  task automatic wait_acks(input int target, input int limit, input string name);
    int t;
    t = 0;
    while (acks < target && t < limit) begin
      step();
      t++;
    end
    check(name, 32'(acks >= target), 32'd1);
  endtask

  initial begin
    int rcyc, base, n0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // single job
    set_addr(0, 4'h5);
    done_delay = 20;
    req = 4'b0001;
    rcyc = cyc;
    wait_acks(1, 100, "t1_ack_seen");
    req = '0;
    check("t1_start_latency", 32'(last_start_cyc - rcyc), 32'd2);
    check("t1_core_addr", 32'(last_start_addr), 32'h5);
    check("t1_ack", 32'(last_ack), 32'b0001);
    check("t1_err", 32'(last_err), 32'd0);
    check("t1_done_to_ack", 32'(last_ack_cyc - last_start_cyc), 32'd21);
    step();
    check("t1_busy_after_ack", 32'(busy), 32'd0);

    // fresh pointer, all four requesting continuously
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    starts_q.delete();
    base = acks;
    done_delay = 3;
    for (int i = 0; i < NREQ; i++) set_addr(i, ADDR_W'(i + 8));
    req = 4'b1111;
    wait_acks(base + 5, 300, "t2_acks_seen");
    req = '0;
    repeat (5) step();
    check("t2_job_count", 32'(starts_q.size()), 32'd5);
    check("t2_ack_count", 32'(acks - base), 32'd5);
    if (starts_q.size() >= 5)
      for (int i = 0; i < 5; i++) check("t2_order", 32'(starts_q[i]), 32'(exp_order[i]));

    // pointer wrap past req2 and re-raised req2 served after req0
    base = acks;
    req = 4'b0100;
    wait_acks(base + 1, 100, "t3_first_ack");
    n0 = starts_q.size();
    req = 4'b0101;
    wait_acks(base + 2, 100, "t3_second_ack");
    req = 4'b0100;
    check("t3_wrap_pick", 32'(starts_q[n0]), 32'd0);
    wait_acks(base + 3, 100, "t3_third_ack");
    req = '0;
    check("t3_then_req2", 32'(last_ack), 32'b0100);

    // watchdog timeout, then a normal job
    base = acks;
    done_delay = -1;
    req = 4'b0010;
    wait_acks(base + 1, 1200, "t4_timeout_ack");
    req = '0;
    check("t4_ack", 32'(last_ack), 32'b0010);
    check("t4_err", 32'(last_err), 32'd1);
    check("t4_timeout_len", 32'(last_ack_cyc - last_start_cyc), 32'd1026);
    done_delay = 5;
    req = 4'b0001;
    wait_acks(base + 2, 100, "t4_next_ack");
    req = '0;
    check("t4_next_err", 32'(last_err), 32'd0);
    check("t4_next_len", 32'(last_ack_cyc - last_start_cyc), 32'd6);

    // stray core_done in IDLE and LAUNCH
    base = acks;
    step();
    stray_now = 1'b1; step(); stray_now = 1'b0;
    repeat (3) step();
    check("t5_idle_no_ack", 32'(acks - base), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    stray_on_start = 1'b1;
    done_delay = 10;
    req = 4'b0001;
    wait_acks(base + 1, 100, "t5_launch_ack");
    req = '0;
    stray_on_start = 1'b0;
    check("t5_launch_len", 32'(last_ack_cyc - last_start_cyc), 32'd11);
    check("t5_launch_err", 32'(last_err), 32'd0);
    repeat (4) step();
    check("t5_one_ack", 32'(acks - base), 32'd1);

    // reset during RUN
    done_delay = -1;
    n0 = starts_q.size();
    req = 4'b0011;
    for (int t = 0; t < 20 && starts_q.size() == n0; t++) step();
    check("t6_launched", 32'(starts_q.size() > n0), 32'd1);
    if (starts_q.size() > n0) check("t6_aborted_idx", 32'(starts_q[n0]), 32'd1);
    repeat (6) step();
    base = acks;
    rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_addr", 32'(core_addr), 32'd0);
    step(); step();
    rst = 1'b0;
    done_delay = 4;
    wait_acks(base + 1, 100, "t6_fresh_ack");
    req = 4'b0010;
    check("t6_fresh_idx0", 32'(last_ack), 32'b0001);
    wait_acks(base + 2, 100, "t6_second_ack");
    req = '0;
    check("t6_second_idx1", 32'(last_ack), 32'b0010);

    // randomised traffic
    base = acks;
    rand_delay = 1'b1;
    for (int t = 0; t < 5000; t++) begin
      step();
      req = req & ~ack;
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = int'($urandom_range(0, NREQ - 1));
        if (((req >> b) & NREQ'(1)) == '0) begin
          set_addr(b, ADDR_W'($urandom));
          req = req | (NREQ'(1) << b);
        end
      end
      stray_now = ($urandom_range(0, 49) == 0);
    end
    stray_now = 1'b0;
    for (int t = 0; t < 1200 && (req != '0 || busy); t++) begin
      step();
      req = req & ~ack;
    end
    req = '0;
    repeat (4) step();
    check("rand_drained", 32'(busy), 32'd0);
    check("rand_progress", 32'((acks - base) > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_job_scheduler.md
Name: mult_job_scheduler

Overview:
- Round-robin scheduler sharing one approximate-multiplier core among NREQ requesters.
- Each requester supplies an input-RAM base address. The scheduler grants one requester, loads that address into the core, and pulses the core start.
- It waits for core done (or a watchdog timeout), then returns a one-cycle ack, with an error flag on timeout, to the granted requester.
- Sits between requester blocks and the multiplier top, which holds the core controller and datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 4, input-RAM base address width.
- TMO_W, 10, watchdog counter width; timeout fires at count 2^TMO_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester job request, level; held until ack.
- req_addr  input  NREQ*ADDR_W  flattened base addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- grant  output  NREQ  one-hot; set from LAUNCH through ACK.
- ack  output  NREQ  one-hot one-cycle pulse marking job completion.
- err  output  1  valid with ack; 1 = job timed out.
- core_start  output  1  start to the core, high exactly one cycle.
- core_addr  output  ADDR_W  latched base address, stable from LAUNCH to ACK.
- core_done  input  1  core completion pulse.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, watchdog 0. Reset mid-job aborts silently: no ack.
- States and transitions:
  - IDLE: if req != 0, go to ARB.
  - ARB: pick the first set req at or above the rr pointer, wrapping round. Latch its index and address. Go to LAUNCH.
  - LAUNCH: core_start=1, grant set. Go to RELEASE.
  - RELEASE: core_start=0. The core waits for start to fall before running. Clear watchdog. Go to RUN.
  - RUN: increment watchdog. If core_done, go to ACK with err=0. Else if watchdog == all-ones, go to ACK with err=1.
  - ACK: ack[idx]=1, err as latched. rr pointer becomes idx+1 mod NREQ. Go to IDLE.
- Latency: req seen in IDLE → core_start two cycles later. core_done → ack on the next cycle.
- core_done outside RUN is ignored.
- core_done in the same cycle the watchdog saturates: done wins, err=0.
- A req dropped before ack is a protocol violation. The job still completes and is acked.
- Requests arriving during a job wait for the next pass through ARB. Back-to-back jobs have 2 idle cycles minimum (ACK→IDLE→ARB).
- Fairness: with all requesters pending, grants go 0,1,2,3,0,...; no requester waits more than NREQ-1 jobs.
- A requester newly raising req equal to the current idx after its ack is served only after the others.

Decomposition:
- Package mult_sched_pkg: state encodings (IDLE, ARB, LAUNCH, RELEASE, RUN, ACK; 3 bits) and the default widths.
- Sub-module rr_arbiter: combinational pick. Inputs req and ptr; outputs one-hot gnt, index, and valid.
- FSM, latches, watchdog and pointer live in the top.

Test Plan:
- Single job: req=0001, addr0=4'h5, core_done 20 cycles after start → core_start one cycle with core_addr=5, ack=0001, err=0, busy falls the cycle after ack.
- All four requesting continuously, core_done 3 cycles after each start → grant order 0,1,2,3,0; exactly one ack per job.
- Pointer wrap: after a req2 job acks, req=0101 → req0 is granted, not req2.
- Timeout: req=0010, core_done never asserted → ack=0010, err=1 at watchdog 1023. Next job proceeds normally.
- Stray core_done during IDLE and LAUNCH → no ack and no state change.
- Reset asserted during RUN → all outputs 0 immediately. After release with req still high, a fresh job launches from grant index 0 with no ack for the aborted job.
